// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants, instruction field positions
// and the fetch state encoding used by the fetch unit and decoder.
package core_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LDR   = 5'b00001;
    localparam logic [4:0] OP_STR   = 5'b00010;
    localparam logic [4:0] OP_BEQ   = 5'b00011;
    localparam logic [4:0] OP_ADDI  = 5'b00100;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int ALUOP_MSB  = 26;
    localparam int ALUOP_LSB  = 24;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_FLUSH = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_legal_chk.sv
// Combinational opcode legality check against the core opcode set.
module opcode_legal_chk
    import core_pkg::*;
(
    input  logic [4:0] i_opcode,
    output logic       o_legal
);

    always_comb begin
        case (i_opcode)
            OP_RTYPE, OP_LDR, OP_STR, OP_BEQ, OP_ADDI: o_legal = 1'b1;
            default:                                   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem request,
// valid/ready hand-off to decode, branch redirect and illegal-opcode halt.
//
// state   | meaning
// S_REQ   | issue fetch at PC
// S_WAIT  | waiting for read data of the live request
// S_HOLD  | instruction presented to decode
// S_FLUSH | waiting for a stale response to discard
// S_HALT  | illegal opcode seen, frozen until reset
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            PC_STEP  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_imem_req,
    output logic [AW-1:0] o_imem_addr,
    input  logic          i_imem_rvalid,
    input  logic [31:0]   i_imem_rdata,
    output logic          o_instr_valid,
    input  logic          i_instr_ready,
    output logic [31:0]   o_instr,
    output logic [4:0]    o_opcode,
    output logic [2:0]    o_aluop,
    output logic [AW-1:0] o_pc_out,
    input  logic          i_branch_taken,
    input  logic [AW-1:0] i_branch_target,
    output logic          o_illegal
);

    fetch_state_t  r_state;
    fetch_state_t  w_next;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_pc_out;
    logic [31:0]   r_instr;
    logic          r_valid;
    logic          r_illegal;
    logic          w_legal;
    logic          w_req;
    logic          w_redirect;
    logic          w_capture;
    logic          w_release;
    logic          w_trap;

    opcode_legal_chk u_legal_chk (
        .i_opcode (r_instr[OPCODE_MSB:OPCODE_LSB]),
        .o_legal  (w_legal)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ:   w_next = i_branch_taken ? S_FLUSH : S_WAIT;
            S_WAIT: begin
                if (i_branch_taken) begin
                    w_next = i_imem_rvalid ? S_REQ : S_FLUSH;
                end else if (i_imem_rvalid) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_branch_taken) begin
                    w_next = S_REQ;
                end else if (!w_legal) begin
                    w_next = S_HALT;
                end else if (i_instr_ready) begin
                    w_next = S_REQ;
                end
            end
            // A response landing with a redirect still ends the flush; the new
            // target has no request in flight yet.
            S_FLUSH: if (i_imem_rvalid) w_next = S_REQ;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_REQ;
        endcase
    end

    // Request is qualified by reset so the bus stays quiet while held in reset.
    always_comb begin
        w_req      = (r_state == S_REQ) && i_rst_n;
        w_redirect = i_branch_taken && (r_state != S_HALT);
        w_capture  = (r_state == S_WAIT) && i_imem_rvalid && !i_branch_taken;
        w_release  = (r_state == S_HOLD) && (i_branch_taken || (i_instr_ready && w_legal));
        w_trap     = (r_state == S_HOLD) && !i_branch_taken && !w_legal;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc      <= RESET_PC;
            r_pc_out  <= '0;
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_pc <= i_branch_target;
            end else if (w_capture) begin
                r_pc <= r_pc + AW'(PC_STEP);
            end
            if (w_capture) begin
                r_instr  <= i_imem_rdata;
                r_pc_out <= r_pc;
                r_valid  <= 1'b1;
            end else if (w_release) begin
                r_valid  <= 1'b0;
            end
            if (w_trap) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign o_imem_req    = w_req;
    assign o_imem_addr   = w_req ? r_pc : '0;
    assign o_instr_valid = r_valid;
    assign o_instr       = r_instr;
    assign o_opcode      = r_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_aluop       = r_instr[ALUOP_MSB:ALUOP_LSB];
    assign o_pc_out      = r_pc_out;
    assign o_illegal     = r_illegal;

endmodule
